muldiv_unit: RTL and testbench

Iterative RV64M multiply/divide unit for the execute stage. Takes the same two 64-bit operand buses that drive the ALU and produces a 64-bit result for the register write-back mux. It needs many cycles per operation, so it uses a start/busy/done handshake, and the control path holds the PC and suppresses register write while `busy` is high.

---
 rtl/muldiv_unit.sv | 149 ++++++++++++++
 tb/tb_muldiv_unit.sv | 120 ++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: 64 radix-2 steps plus one fix-up cycle, start/busy/done handshake.
// Optional *W variants are built when MULDIV_WORD_EN is defined.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] A1,
    input  logic [XLEN-1:0] A2,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t            r_state;
    logic [5:0]        r_cnt;
    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_hi, r_lo, r_m, r_dvd, r_result;
    logic              r_neg, r_rneg, r_dz, r_ovf;

    logic              w_a_signed, w_b_signed, w_is_div, w_word;
    logic [XLEN-1:0]   w_a_src, w_b_src, w_ma, w_mb, w_ovf_a;

    assign w_is_div   = op[2];
    assign w_a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign w_b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);

`ifdef MULDIV_WORD_EN
    logic r_word;
    assign w_word  = word;
    assign w_a_src = !word ? A1 : {{32{w_a_signed & A1[31]}}, A1[31:0]};
    assign w_b_src = !word ? A2 : {{32{w_b_signed & A2[31]}}, A2[31:0]};
    assign w_ovf_a = word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
`else
    logic w_unused_word;
    assign w_unused_word = word;
    assign w_word  = 1'b0;
    assign w_a_src = A1;
    assign w_b_src = A2;
    assign w_ovf_a = 64'h8000_0000_0000_0000;
`endif

    assign w_ma = (w_a_signed && w_a_src[XLEN-1]) ? -w_a_src : w_a_src;
    assign w_mb = (w_b_signed && w_b_src[XLEN-1]) ? -w_b_src : w_b_src;

    // Multiply: r_lo holds the multiplier shifting out, r_hi accumulates.
    // Divide: r_lo holds the dividend shifting into r_hi, quotient bits shift in at the bottom.
    logic [XLEN:0]     w_sum, w_shift;
    logic [XLEN-1:0]   w_diff;
    logic              w_ge;
    assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_m : {XLEN{1'b0}})};
    assign w_shift = {r_hi, r_lo[XLEN-1]};
    assign w_ge    = w_shift >= {1'b0, r_m};
    assign w_diff  = w_shift[XLEN-1:0] - r_m;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_sel, w_fix;
    always_comb begin
        w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quo  = r_neg  ? -r_lo : r_lo;
        w_rem  = r_rneg ? -r_hi : r_hi;
        if (r_dz) begin
            w_quo = {XLEN{1'b1}};
            w_rem = r_dvd;
        end else if (r_ovf) begin
            w_quo = r_dvd;
            w_rem = {XLEN{1'b0}};
        end
        if (r_op[2])
            w_sel = r_op[1] ? w_rem : w_quo;
        else
            w_sel = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef MULDIV_WORD_EN
        w_fix = r_word ? {{32{w_sel[31]}}, w_sel[31:0]} : w_sel;
`else
        w_fix = w_sel;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_m      <= '0;
            r_dvd    <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef MULDIV_WORD_EN
            r_word   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_op    <= op;
                        r_hi    <= '0;
                        r_lo    <= w_is_div ? w_ma : w_mb;
                        r_m     <= w_is_div ? w_mb : w_ma;
                        r_dvd   <= w_a_src;
                        r_neg   <= (w_a_signed & w_a_src[XLEN-1]) ^ (w_b_signed & w_b_src[XLEN-1]);
                        r_rneg  <= w_a_signed & w_a_src[XLEN-1];
                        r_dz    <= w_is_div && (w_b_src == '0);
                        r_ovf   <= w_is_div && !op[0] && (w_a_src == w_ovf_a) && (w_b_src == '1);
`ifdef MULDIV_WORD_EN
                        r_word  <= w_word;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_op[2]) begin
                        r_hi <= w_ge ? w_diff : w_shift[XLEN-1:0];
                        r_lo <= {r_lo[XLEN-2:0], w_ge};
                    end else begin
                        r_hi <= w_sum[XLEN:1];
                        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd63) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_result <= w_fix;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign result = r_result;
    assign busy   = (r_state == S_RUN) || (r_state == S_FIX);
    assign done   = (r_state == S_DONE);

    logic w_unused_cfg;
    assign w_unused_cfg = w_word;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, signed/unsigned mul/div, special cases, start/rst robustness.
// Word-variant vectors run only when MULDIV_WORD_EN is defined.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst, start, word;
    logic [2:0]  op;
    logic [63:0] A1, A2, result;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_done;

    muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .word(word),
        .A1(A1), .A2(A2), .result(result), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Launch one op and wait for done; optionally pulse a foreign start at cycle inj of the run.
    task automatic run(input string tag, input logic [2:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int inj);
        int n, nb;
        @(negedge clk);
        op = o; word = w; A1 = a; A2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; nb = 0;
        while (!done && n < 200) begin
            if (busy) nb++;
            start = (n == inj);
            if (n == inj) begin op = 3'b000; A1 = 64'd3; A2 = 64'd3; end
            else begin A1 = {$urandom, $urandom}; A2 = {$urandom, $urandom}; end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        t_done = cyc;
        chk({tag, " latency"}, 64'(n), 64'd65);
        chk({tag, " busy_cycles"}, 64'(nb), 64'd65);
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        chk({tag, " result"}, result, exp);
    endtask

    initial begin
        int t1, nd;
        rst = 1'b1; start = 1'b0; word = 1'b0; op = 3'b000; A1 = '0; A2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", result, 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle done", 64'(done), 64'd0);

        run("MUL 6x7",      3'b000, 1'b0, 64'd6, 64'd7, 64'd42, -1);
        run("MULHU max",    3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, -1);
        run("MULH -1x-1",   3'b001, 1'b0, '1, '1, 64'd0, -1);
        run("MULHSU -1x2",  3'b010, 1'b0, '1, 64'd2, '1, -1);
        run("MUL neg",      3'b000, 1'b0, -64'sd3, 64'd5, -64'sd15, -1);
        run("DIV -7/2",     3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1);
        run("REM -7/2",     3'b110, 1'b0, -64'sd7, 64'd2, '1, -1);
        run("DIVU 100/7",   3'b101, 1'b0, 64'd100, 64'd7, 64'd14, -1);
        run("REMU 100/7",   3'b111, 1'b0, 64'd100, 64'd7, 64'd2, -1);
        run("DIVU 5/0",     3'b101, 1'b0, 64'd5, 64'd0, '1, -1);
        run("REMU 5/0",     3'b111, 1'b0, 64'd5, 64'd0, 64'd5, -1);
        run("REM -7/0",     3'b110, 1'b0, -64'sd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFF9, -1);
        run("DIV ovf",      3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, -1);
        run("REM ovf",      3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, -1);
`ifdef MULDIV_WORD_EN
        run("MULW",         3'b000, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, -1);
        run("DIVUW",        3'b101, 1'b1, 64'hFFFF_FFFF, 64'd1, '1, -1);
        run("DIVW -8/2",    3'b100, 1'b1, 64'h0000_0001_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC, -1);
`endif

        // foreign start mid-run must not disturb the op in flight
        run("start_busy",   3'b101, 1'b0, 64'd1000, 64'd10, 64'd100, 10);

        // back-to-back: second start issued in the DONE cycle
        t1 = t_done;
        run("b2b",          3'b000, 1'b0, 64'd11, 64'd13, 64'd143, -1);
        chk("b2b spacing", 64'(t_done - t1), 64'd66);

        // reset mid-operation
        @(negedge clk);
        op = 3'b000; word = 1'b0; A1 = 64'd9; A2 = 64'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst result", result, 64'd0);
        rst = 1'b0;
        nd = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (done) nd++;
        end
        chk("rst no_done", 64'(nd), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
